// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_pkg
// Description : Shared constants and types for the direct-mapped instruction
//               cache: default geometry, bus width, boolean constants and the
//               controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package icache_pkg;

    localparam int ICACHE_INDEX_BITS = 6;   // 64 lines
    localparam int ICACHE_WORD_BITS  = 2;   // 4 words per line
    localparam int ICACHE_ADDR_BITS  = 18;  // physical address bits decoded
    localparam int ICACHE_TAG_BITS   = ICACHE_ADDR_BITS - 2 - ICACHE_WORD_BITS - ICACHE_INDEX_BITS;

    localparam int   DATA_BUS = 32;
    localparam logic TRUE     = 1'b1;
    localparam logic FALSE    = 1'b0;

    typedef enum logic [1:0] {
        ICACHE_IDLE    = 2'd0,
        ICACHE_REFILL  = 2'd1,
        ICACHE_RESPOND = 2'd2
    } icache_state_t;

endpackage : icache_pkg
`default_nettype wire

// File: rtl/icache_data_array.sv
`default_nettype none
// ============================================================================
// Module      : icache_data_array
// Description : Instruction word storage for the cache. One synchronous write
//               port used by the refill engine and one asynchronous read port
//               shared by hit lookup and the post-refill response.
// Ports       : clk                  - clock
//               wr_en/wr_index/wr_word/wr_data - write port
//               rd_index/rd_word     - read address
//               rd_data              - read data (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module icache_data_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int WORD_BITS  = ICACHE_WORD_BITS,
    parameter int DATA_W     = DATA_BUS
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [WORD_BITS-1:0]  wr_word,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [INDEX_BITS-1:0] rd_index,
    input  logic [WORD_BITS-1:0]  rd_word,
    output logic [DATA_W-1:0]     rd_data
);

    localparam int c_depth = 1 << (INDEX_BITS + WORD_BITS);

    logic [DATA_W-1:0] r_mem [c_depth];

    // Storage needs no reset: a line is only ever read after its valid bit is
    // set, which happens only once all of its words have been written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[{wr_index, wr_word}] <= wr_data;
        end
    end

    assign rd_data = r_mem[{rd_index, rd_word}];

endmodule : icache_data_array
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module      : icache
// Description : Direct-mapped instruction cache. Hits answer one cycle after
//               acceptance; misses refill the whole line from the memory
//               controller word by word, then answer from the array.
// Ports       : clk, rst (sync, active-high), rdy (global freeze)
//               clr            - cancels any pending response
//               addr, rn       - fetch request
//               Inst, Read_ready - response (Read_ready is a 1-cycle pulse)
//               mem_req, mem_addr, mem_data, mem_valid - refill interface
// Revision    : 1.0 - initial release
// ============================================================================
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int WORD_BITS  = ICACHE_WORD_BITS,
    parameter int ADDR_BITS  = ICACHE_ADDR_BITS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                clr,
    input  logic [31:0]         addr,
    input  logic                rn,
    output logic [DATA_BUS-1:0] Inst,
    output logic                Read_ready,
    output logic                mem_req,
    output logic [31:0]         mem_addr,
    input  logic [DATA_BUS-1:0] mem_data,
    input  logic                mem_valid
);

    localparam int c_lines    = 1 << INDEX_BITS;
    localparam int c_off_lo   = 2;
    localparam int c_idx_lo   = 2 + WORD_BITS;
    localparam int c_tag_lo   = 2 + WORD_BITS + INDEX_BITS;
    localparam int c_tag_bits = ADDR_BITS - c_tag_lo;
    localparam logic [WORD_BITS-1:0] c_last_word = '1;

    icache_state_t              r_state;
    logic [c_lines-1:0]         r_valid;
    logic [c_tag_bits-1:0]      r_tag [c_lines];
    logic [ADDR_BITS-1:2]       r_req_addr;
    logic [WORD_BITS-1:0]       r_cnt;
    logic                       r_cancel;

    logic [INDEX_BITS-1:0]      w_in_index;
    logic [WORD_BITS-1:0]       w_in_word;
    logic [c_tag_bits-1:0]      w_in_tag;
    logic [INDEX_BITS-1:0]      w_req_index;
    logic [WORD_BITS-1:0]       w_req_word;
    logic [c_tag_bits-1:0]      w_req_tag;
    logic                       w_hit;
    logic                       w_accept;
    logic                       w_fill;
    logic                       w_fill_last;
    logic [INDEX_BITS-1:0]      w_rd_index;
    logic [WORD_BITS-1:0]       w_rd_word;
    logic [DATA_BUS-1:0]        w_rd_data;
    logic [33-ADDR_BITS:0]      w_unused_addr;

    assign w_unused_addr = {addr[31:ADDR_BITS], addr[1:0]};

    assign w_in_index  = addr[c_idx_lo +: INDEX_BITS];
    assign w_in_word   = addr[c_off_lo +: WORD_BITS];
    assign w_in_tag    = addr[ADDR_BITS-1:c_tag_lo];
    assign w_req_index = r_req_addr[c_idx_lo +: INDEX_BITS];
    assign w_req_word  = r_req_addr[c_off_lo +: WORD_BITS];
    assign w_req_tag   = r_req_addr[ADDR_BITS-1:c_tag_lo];

    assign w_hit = r_valid[w_in_index] && (r_tag[w_in_index] == w_in_tag);

    // Read_ready=0 is part of acceptance: the fetcher still holds rn on the
    // edge where it sees the pulse, and that must not start a second request.
    assign w_accept = (r_state == ICACHE_IDLE) && rn && !Read_ready && !clr;

    assign w_fill      = rdy && (r_state == ICACHE_REFILL) && mem_valid;
    assign w_fill_last = w_fill && (r_cnt == c_last_word);

    // The single read port serves the live fetch address while idle and the
    // latched request when answering after a refill.
    assign w_rd_index = (r_state == ICACHE_IDLE) ? w_in_index : w_req_index;
    assign w_rd_word  = (r_state == ICACHE_IDLE) ? w_in_word  : w_req_word;

    icache_data_array #(
        .INDEX_BITS (INDEX_BITS),
        .WORD_BITS  (WORD_BITS),
        .DATA_W     (DATA_BUS)
    ) u_data_array (
        .clk      (clk),
        .wr_en    (w_fill),
        .wr_index (w_req_index),
        .wr_word  (r_cnt),
        .wr_data  (mem_data),
        .rd_index (w_rd_index),
        .rd_word  (w_rd_word),
        .rd_data  (w_rd_data)
    );

    // Tags are qualified by r_valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (w_fill_last) begin
            r_tag[w_req_index] <= w_req_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ICACHE_IDLE;
            r_valid    <= '0;
            r_req_addr <= '0;
            r_cnt      <= '0;
            r_cancel   <= FALSE;
            Inst       <= '0;
            Read_ready <= FALSE;
            mem_req    <= FALSE;
            mem_addr   <= '0;
        end else if (rdy) begin
            Read_ready <= FALSE;
            unique case (r_state)
                ICACHE_IDLE: begin
                    if (w_accept) begin
                        r_req_addr <= addr[ADDR_BITS-1:2];
                        r_cancel   <= FALSE;
                        if (w_hit) begin
                            Inst       <= w_rd_data;
                            Read_ready <= TRUE;
                        end else begin
                            r_state  <= ICACHE_REFILL;
                            r_cnt    <= '0;
                            mem_req  <= TRUE;
                            mem_addr <= {{(32-ADDR_BITS){1'b0}}, addr[ADDR_BITS-1:c_idx_lo],
                                         {WORD_BITS{1'b0}}, 2'b00};
                        end
                    end
                end
                ICACHE_REFILL: begin
                    // A flush cannot abort the memory transfer; it only
                    // silences the response once the line is installed.
                    if (clr) begin
                        r_cancel <= TRUE;
                    end
                    if (mem_valid) begin
                        r_cnt    <= r_cnt + 1'b1;
                        mem_addr <= mem_addr + 32'd4;
                        if (r_cnt == c_last_word) begin
                            r_valid[w_req_index] <= TRUE;
                            mem_req              <= FALSE;
                            r_state              <= ICACHE_RESPOND;
                        end
                    end
                end
                ICACHE_RESPOND: begin
                    if (!r_cancel && !clr) begin
                        Inst       <= w_rd_data;
                        Read_ready <= TRUE;
                    end
                    r_cancel <= FALSE;
                    r_state  <= ICACHE_IDLE;
                end
                default: begin
                    r_state <= ICACHE_IDLE;
                end
            endcase
        end
    end

endmodule : icache
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache
// Description : Self-checking bench for icache. A driver issues fetches and
//               plays the memory controller; a reference model of the cache
//               contents (valid/tag per line, memory as a pure function of
//               address) predicts hit/miss, latency and data. Expected
//               instruction words go to a queue consumed by a monitor that
//               fires on every Read_ready pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache;

    localparam int M_NONE     = 0;
    localparam int M_CLR      = 1;  // flush after the 2nd refill word
    localparam int M_STALL    = 2;  // rdy low 3 cycles after the 2nd word
    localparam int M_RESET    = 3;  // reset after the 2nd refill word
    localparam int M_CLR_IDLE = 4;  // clr together with the first rn cycle

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        clr;
    logic [31:0] addr;
    logic        rn;
    logic [31:0] Inst;
    logic        Read_ready;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_valid;

    int n_checks = 0;
    int n_err    = 0;

    logic [31:0] exp_q[$];
    bit   [63:0] ref_valid;
    logic [7:0]  ref_tag [64];

    icache dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .clr        (clr),
        .addr       (addr),
        .rn         (rn),
        .Inst       (Inst),
        .Read_ready (Read_ready),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_valid  (mem_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory: directed words for the line at 0x10, a hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = a & 32'h0003_FFFC;
        if (w >= 32'h10 && w < 32'h20) return 32'hA0 + ((w - 32'h10) >> 2);
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Scoreboard consumer: every Read_ready pulse must match the oldest
    // outstanding expectation.
    always @(negedge clk) begin
        if (Read_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_rr: Read_ready=1 Inst=%h with no pending request at %0t", Inst, $time);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (Inst !== e) begin
                    n_err++;
                    $display("FAIL inst_data: got %h expected %h at %0t", Inst, e, $time);
                end
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_read_ready", {31'b0, Read_ready}, 32'd0);
        check("rst_inst",       Inst,                32'd0);
        check("rst_mem_req",    {31'b0, mem_req},    32'd0);
        check("rst_mem_addr",   mem_addr,            32'd0);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge.
    task automatic do_fetch(input logic [31:0] a, input int mode_in);
        int          mode, cyc, nwords, last_pulse, stall_left, exp_lat;
        bit          hit, got, done, trig;
        logic [5:0]  idx;
        logic [7:0]  tg;
        logic [31:0] base;

        mode = mode_in;
        idx  = a[9:4];
        tg   = a[17:10];
        hit  = ref_valid[idx] && (ref_tag[idx] == tg);
        if (hit && (mode == M_CLR || mode == M_STALL || mode == M_RESET)) mode = M_NONE;
        base = a & 32'h0003_FFF0;
        if (!hit && mode != M_RESET) begin
            ref_valid[idx] = 1'b1;
            ref_tag[idx]   = tg;
        end
        if (mode != M_CLR && mode != M_RESET) exp_q.push_back(mem_word(a));

        addr = a;
        rn   = 1'b1;
        clr  = (mode == M_CLR_IDLE);
        cyc = 0; nwords = 0; last_pulse = 0; stall_left = 0;
        got = 0; done = 0; trig = 0;

        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            mem_valid = 1'b0;
            clr       = 1'b0;
            if (stall_left > 0) begin
                check("stall_mem_req",  {31'b0, mem_req}, 32'd1);
                check("stall_mem_addr", mem_addr, base + 32'(nwords * 4));
                stall_left--;
                if (stall_left == 0) begin
                    rdy = 1'b1;
                end else begin
                    mem_valid = 1'b1;            // must be ignored while frozen
                    mem_data  = 32'hDEAD_BEEF;
                end
                continue;
            end
            if (got) begin
                check("rr_one_cycle", {31'b0, Read_ready}, 32'd0);
                rn   = 1'b0;
                done = 1;
                break;
            end
            if (Read_ready) begin
                got     = 1;
                exp_lat = hit ? (1 + int'(mode == M_CLR_IDLE)) : (last_pulse + 2);
                check("latency", 32'(cyc), 32'(exp_lat));
            end
            if (nwords == 4 && cyc == last_pulse + 1)
                check("mem_req_drop", {31'b0, mem_req}, 32'd0);
            if (mode == M_CLR && nwords == 4 && cyc >= last_pulse + 4) begin
                check("cancel_silent", {31'b0, got}, 32'd0);
                done = 1;
                break;
            end
            if (!trig && nwords == 2 && (mode == M_CLR || mode == M_STALL || mode == M_RESET)) begin
                trig = 1;
                if (mode == M_CLR) begin
                    clr = 1'b1;
                    rn  = 1'b0;
                end else if (mode == M_STALL) begin
                    rdy        = 1'b0;
                    stall_left = 3;
                    mem_valid  = 1'b1;
                    mem_data   = 32'hDEAD_BEEF;
                    continue;
                end else begin
                    rst = 1'b1;
                    rn  = 1'b0;
                    @(negedge clk);
                    @(negedge clk);
                    rst = 1'b0;
                    check_reset_outputs();
                    ref_valid = '0;
                    done = 1;
                    break;
                end
            end
            if (rdy && mem_req && nwords < 4 && $urandom_range(0, 3) != 0) begin
                check("refill_addr", mem_addr, base + 32'(nwords * 4));
                mem_data   = mem_word(mem_addr);
                mem_valid  = 1'b1;
                nwords++;
                last_pulse = cyc;
            end
        end
        check("fetch_done", {31'b0, done}, 32'd1);
        if (!done) begin
            rn = 1'b0; rdy = 1'b1; clr = 1'b0; mem_valid = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] a;
        int          m;
        rst = 1'b1; rdy = 1'b1; clr = 1'b0; rn = 1'b0;
        addr = '0; mem_data = '0; mem_valid = 1'b0;
        ref_valid = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        @(negedge clk);

        do_fetch(32'h0000_0010, M_NONE);      // cold miss, words A0..A3
        do_fetch(32'h0000_0018, M_NONE);      // hit, A2
        do_fetch(32'h0000_0410, M_NONE);      // same index, new tag: miss
        do_fetch(32'h0000_0010, M_NONE);      // evicted: miss again
        do_fetch(32'h0000_0030, M_CLR);       // flushed mid-refill
        do_fetch(32'h0000_0034, M_NONE);      // line still installed: hit
        do_fetch(32'h0000_0050, M_STALL);     // frozen mid-refill
        do_fetch(32'h0000_0058, M_CLR_IDLE);  // hit delayed by idle flush
        do_fetch(32'h0000_0060, M_CLR_IDLE);  // miss delayed by idle flush
        do_fetch(32'hFFFC_0017, M_NONE);      // ignored upper/low bits: hit 0x14

        // Back-to-back random fetches over a few tags and indexes so that
        // hits, misses and evictions all occur.
        for (int i = 0; i < 40; i++) begin
            a       = $urandom;
            a[17:10] = 8'($urandom_range(0, 3));
            a[9:4]   = 6'($urandom_range(0, 7));
            m = $urandom_range(0, 9);
            m = (m < 6) ? M_NONE : (m - 5);
            if (m == M_RESET) m = M_NONE;
            do_fetch(a, m);
        end

        do_fetch(32'h0003_FF90, M_RESET);     // reset abandons the refill
        do_fetch(32'h0003_FF90, M_NONE);      // line invalid: miss
        do_fetch(32'h0000_0010, M_NONE);      // all lines invalid: miss

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_icache
`default_nettype wire
